// File: rtl/seq_play_core.sv
// seq_play_core: bus-programmable pattern player.
// Bytes are written into a pattern memory over the 8-bit register bus. A START
// replays the stored words on SEQ_OUT at a programmable rate and repeat count.
// Optional feature macro: SEQ_PLAY_EXT_START_EN (external start via SEQ_EXT_START
// when register 2 bit0 is set).
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no words issued; DONE holds once the last pass has drained
// RUN    | word addresses issued to memory; outputs trail by two cycles
module seq_play_core #(
    parameter int MEM_BYTES = 8 * 1024,
    parameter int ABUSWIDTH = 16,
    parameter int OUT_BITS  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 SEQ_EXT_START,
    output logic [OUT_BITS-1:0]  SEQ_OUT,
    output logic                 SEQ_ACTIVE
);
    localparam int BPW = OUT_BITS / 8;
    localparam int WORDS = MEM_BYTES / BPW;
    localparam int MA = $clog2(MEM_BYTES);
    localparam logic [15:0] WORDS16 = 16'(WORDS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [7:0] pat_mem [MEM_BYTES];

    logic [31:0] add32;
    logic        soft_rst, rst, wr_start, start, in_mem;
    logic [MA-1:0] mem_off, play_base;

    state_t        state_q, state_d;
    logic [15:0]   conf_count_q, conf_count_d, count_eff;
    logic [7:0]    conf_repeat_q, conf_repeat_d, conf_div_q, conf_div_d;
    logic [15:0]   word_cnt_q, word_cnt_d, count_run_q, count_run_d;
    logic [7:0]    div_cnt_q, div_cnt_d, div_run_q, div_run_d, rep_cnt_q, rep_cnt_d;
    logic          fin_p0, fin_p1_q, fin_p1_d, fin_p2_q, fin_p2_d, done_q, done_d;
    logic          act_p1_q, act_p1_d, seq_active_q, seq_active_d;
    logic [OUT_BITS-1:0] play_rd_q, play_rd_d, seq_out_q, seq_out_d;
    logic [7:0]    reg_rd_q, reg_rd_d, bus_mem_q, bus_mem_d;
    logic          is_mem_q, is_mem_d;

    assign add32     = 32'(BUS_ADD);
    assign soft_rst  = BUS_WR && (add32 == 32'd0);
    assign rst       = BUS_RST || soft_rst;
    assign wr_start  = BUS_WR && (add32 == 32'd1);
    assign in_mem    = (add32 >= 32'd16) && (add32 < 32'(16 + MEM_BYTES));
    assign mem_off   = MA'(add32 - 32'd16);
    assign play_base = MA'(32'(word_cnt_q) * BPW);
    assign count_eff = (conf_count_q > WORDS16) ? WORDS16 : conf_count_q;

`ifdef SEQ_PLAY_EXT_START_EN
    logic conf_ext_q, conf_ext_d;
    assign start = wr_start || (conf_ext_q && SEQ_EXT_START);

    // external-start enable register
    always_comb begin
        conf_ext_d = conf_ext_q;
        if (BUS_WR && add32 == 32'd2) conf_ext_d = BUS_DATA_IN[0];
    end

    // external-start enable flop
    always_ff @(posedge BUS_CLK) begin
        if (rst) conf_ext_q <= 1'b0;
        else     conf_ext_q <= conf_ext_d;
    end
`else
    logic unused_ext_start;
    assign unused_ext_start = SEQ_EXT_START;
    assign start = wr_start;
`endif

    // configuration register writes
    always_comb begin
        conf_count_d  = conf_count_q;
        conf_repeat_d = conf_repeat_q;
        conf_div_d    = conf_div_q;
        if (BUS_WR) begin
            case (add32)
                32'd3: conf_count_d[7:0]  = BUS_DATA_IN;
                32'd4: conf_count_d[15:8] = BUS_DATA_IN;
                32'd5: conf_repeat_d      = BUS_DATA_IN;
                32'd6: conf_div_d         = BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // bus read capture: registers sampled now, data presented next cycle
    always_comb begin
        reg_rd_d  = reg_rd_q;
        is_mem_d  = is_mem_q;
        bus_mem_d = bus_mem_q;
        if (BUS_RD) begin
            is_mem_d = in_mem;
            reg_rd_d = 8'h00;
            case (add32)
                32'd1: reg_rd_d = {7'b0, done_q};
`ifdef SEQ_PLAY_EXT_START_EN
                32'd2: reg_rd_d = {7'b0, conf_ext_q};
`endif
                32'd3: reg_rd_d = conf_count_q[7:0];
                32'd4: reg_rd_d = conf_count_q[15:8];
                32'd5: reg_rd_d = conf_repeat_q;
                32'd6: reg_rd_d = conf_div_q;
                default: ;
            endcase
            if (in_mem) bus_mem_d = pat_mem[mem_off];
        end
    end

    // playback word fetch; lower byte address carries the MSB
    always_comb begin
        play_rd_d = '0;
        for (int i = 0; i < BPW; i++)
            play_rd_d[OUT_BITS-1-8*i -: 8] = pat_mem[play_base + MA'(i)];
    end

    // FSM next state, counters and output pipeline
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        div_cnt_d   = div_cnt_q;
        div_run_d   = div_run_q;
        rep_cnt_d   = rep_cnt_q;
        count_run_d = count_run_q;
        fin_p0      = 1'b0;
        if (state_q == S_RUN) begin
            if (div_cnt_q == div_run_q) begin
                div_cnt_d = 8'd0;
                div_run_d = conf_div_q;
                if (word_cnt_q == count_run_q - 16'd1) begin
                    if (rep_cnt_q == 8'd1 || count_eff == 16'd0) begin
                        state_d = S_IDLE;
                        fin_p0  = 1'b1;
                    end else begin
                        word_cnt_d  = 16'd0;
                        count_run_d = count_eff;
                        if (rep_cnt_q != 8'd0) rep_cnt_d = rep_cnt_q - 8'd1;
                    end
                end else begin
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
        if (start) begin
            word_cnt_d  = 16'd0;
            div_cnt_d   = 8'd0;
            div_run_d   = conf_div_q;
            rep_cnt_d   = conf_repeat_q;
            count_run_d = count_eff;
            state_d     = (count_eff == 16'd0) ? S_IDLE : S_RUN;
        end
        // the finish marker rides the same two-stage delay as the data
        fin_p1_d     = start ? 1'b0 : fin_p0;
        fin_p2_d     = start ? (count_eff == 16'd0) : fin_p1_q;
        done_d       = start ? 1'b0 : (done_q || fin_p2_q);
        act_p1_d     = (state_q == S_RUN);
        seq_active_d = act_p1_q;
        seq_out_d    = act_p1_q ? play_rd_q : '0;
    end

    // pattern memory byte write port
    always_ff @(posedge BUS_CLK) begin
        if (BUS_WR && in_mem) pat_mem[mem_off] <= BUS_DATA_IN;
    end

    // state and register flops
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state_q       <= S_IDLE;
            conf_count_q  <= WORDS16;
            conf_repeat_q <= 8'd1;
            conf_div_q    <= 8'd0;
            word_cnt_q    <= 16'd0;
            count_run_q   <= 16'd0;
            div_cnt_q     <= 8'd0;
            div_run_q     <= 8'd0;
            rep_cnt_q     <= 8'd0;
            fin_p1_q      <= 1'b0;
            fin_p2_q      <= 1'b0;
            done_q        <= 1'b1;
            act_p1_q      <= 1'b0;
            seq_active_q  <= 1'b0;
            play_rd_q     <= '0;
            seq_out_q     <= '0;
            reg_rd_q      <= 8'h00;
            bus_mem_q     <= 8'h00;
            is_mem_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            conf_count_q  <= conf_count_d;
            conf_repeat_q <= conf_repeat_d;
            conf_div_q    <= conf_div_d;
            word_cnt_q    <= word_cnt_d;
            count_run_q   <= count_run_d;
            div_cnt_q     <= div_cnt_d;
            div_run_q     <= div_run_d;
            rep_cnt_q     <= rep_cnt_d;
            fin_p1_q      <= fin_p1_d;
            fin_p2_q      <= fin_p2_d;
            done_q        <= done_d;
            act_p1_q      <= act_p1_d;
            seq_active_q  <= seq_active_d;
            play_rd_q     <= play_rd_d;
            seq_out_q     <= seq_out_d;
            reg_rd_q      <= reg_rd_d;
            bus_mem_q     <= bus_mem_d;
            is_mem_q      <= is_mem_d;
        end
    end

    assign BUS_DATA_OUT = is_mem_q ? bus_mem_q : reg_rd_q;
    assign SEQ_OUT      = seq_out_q;
    assign SEQ_ACTIVE   = seq_active_q;
endmodule

// File: tb/tb_seq_play_core.sv
// Directed bench for seq_play_core (MEM_BYTES=8192, OUT_BITS=8).
module tb_seq_play_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] add = 16'd0;
    logic [7:0]  din = 8'd0;
    logic        rd = 1'b0, wr = 1'b0, ext = 1'b0;
    logic [7:0]  dout;
    logic [7:0]  sout;
    logic        sact;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
    } rd_vec_t;

    rd_vec_t rv_reset [8];
    rd_vec_t rv_conf  [4];
    logic [7:0] pat [4];

    seq_play_core #(.MEM_BYTES(8192), .ABUSWIDTH(16), .OUT_BITS(8)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(add), .BUS_DATA_IN(din),
        .BUS_RD(rd), .BUS_WR(wr), .BUS_DATA_OUT(dout),
        .SEQ_EXT_START(ext), .SEQ_OUT(sout), .SEQ_ACTIVE(sact)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        wr = 1'b1; add = a; din = d;
        @(posedge clk); #1;
        wr = 1'b0; add = 16'd0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        rd = 1'b1; add = a;
        @(posedge clk); #1;
        rd = 1'b0; add = 16'd0;
        d = dout;
    endtask

    // Starts playback at edge k, then checks SEQ_OUT/SEQ_ACTIVE after edges
    // k+2..k+ncyc against the ideal schedule; reads DONE at edges r1/r2.
    task automatic play_check(input int cnt, input int dv, input int rep, input int ncyc,
                              input int r1, input int r2, input string nm, input bit use_ext);
        int total, fin, act_cnt, w;
        logic [7:0] exp_o;
        logic exp_a;
        total = cnt * (dv + 1) * rep;
        fin = (cnt == 0) ? 1 : 2 + total;
        if (rep == 0 && cnt != 0) fin = 1 << 30;
        act_cnt = 0;
        if (use_ext) ext = 1'b1;
        else begin wr = 1'b1; add = 16'd1; din = 8'd0; end
        @(posedge clk); #1;
        ext = 1'b0; wr = 1'b0; add = 16'd0;
        for (int t = 1; t <= ncyc; t++) begin
            rd  = (t == r1 || t == r2);
            add = rd ? 16'd1 : 16'd0;
            @(posedge clk); #1;
            rd = 1'b0; add = 16'd0;
            exp_a = (cnt != 0) && (t >= 2) && (t < fin);
            w = exp_a ? ((t - 2) / (dv + 1)) % cnt : 0;
            exp_o = exp_a ? pat[w] : 8'h00;
            if (t >= 2) begin
                chk({nm, " seq_out"}, 32'(sout), 32'(exp_o));
                chk({nm, " seq_active"}, 32'(sact), 32'(exp_a));
                if (sact) act_cnt++;
            end
            if (t == r1 || t == r2)
                chk({nm, " done"}, 32'(dout), (t - 1 >= fin) ? 32'd1 : 32'd0);
        end
        if (rep != 0) chk({nm, " active cycles"}, 32'(act_cnt), 32'(total));
    endtask

    initial begin
        logic [7:0] rdat;
        int n;
        pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3; pat[3] = 8'hA4;
        rv_reset[0] = '{16'd0, 8'h00};
        rv_reset[1] = '{16'd1, 8'h01};
        rv_reset[2] = '{16'd2, 8'h00};
        rv_reset[3] = '{16'd3, 8'h00};
        rv_reset[4] = '{16'd4, 8'h20};
        rv_reset[5] = '{16'd5, 8'h01};
        rv_reset[6] = '{16'd6, 8'h00};
        rv_reset[7] = '{16'h3000, 8'h00};
        rv_conf[0] = '{16'd17, 8'hA2};
        rv_conf[1] = '{16'd19, 8'hA4};
        rv_conf[2] = '{16'd3, 8'h04};
        rv_conf[3] = '{16'd9, 8'h00};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset seq_out", 32'(sout), 32'd0);
        chk("reset seq_active", 32'(sact), 32'd0);
        chk("reset bus_data_out", 32'(dout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_rd(rv_reset[i].addr, rdat);
            chk($sformatf("reset read @%0h", rv_reset[i].addr), 32'(rdat), 32'(rv_reset[i].exp));
        end

        for (int i = 0; i < 4; i++) bus_wr(16'(16 + i), pat[i]);
        bus_wr(16'd3, 8'd4); bus_wr(16'd4, 8'd0); bus_wr(16'd5, 8'd1); bus_wr(16'd6, 8'd0);
        bus_wr(16'd9, 8'h55);
        for (int i = 0; i < 4; i++) begin
            bus_rd(rv_conf[i].addr, rdat);
            chk($sformatf("conf read @%0h", rv_conf[i].addr), 32'(rdat), 32'(rv_conf[i].exp));
        end

        play_check(4, 0, 1, 8, 3, 8, "four words", 1'b0);

        bus_wr(16'd6, 8'd2); bus_wr(16'd5, 8'd2);
        play_check(4, 2, 2, 28, 10, 28, "div2 rep2", 1'b0);

        // restart three edges into a run
        bus_wr(16'd6, 8'd0); bus_wr(16'd5, 8'd1);
        bus_wr(16'd1, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        play_check(4, 0, 1, 8, 3, 8, "restart", 1'b0);

        bus_wr(16'd3, 8'd0);
        play_check(0, 0, 1, 5, 1, 2, "count zero", 1'b0);

        bus_wr(16'd3, 8'd2); bus_wr(16'd5, 8'd0);
        play_check(2, 0, 0, 30, 0, 0, "infinite", 1'b0);
        bus_wr(16'd0, 8'd0);
        chk("soft reset seq_out", 32'(sout), 32'd0);
        chk("soft reset seq_active", 32'(sact), 32'd0);
        bus_rd(16'd4, rdat); chk("soft reset count hi", 32'(rdat), 32'h20);
        bus_rd(16'd5, rdat); chk("soft reset repeat", 32'(rdat), 32'h01);
        bus_rd(16'd17, rdat); chk("memory kept over soft reset", 32'(rdat), 32'hA2);

        // COUNT above memory size plays the whole memory once
        bus_wr(16'd4, 8'h30);
        bus_wr(16'd1, 8'd0);
        n = 0;
        for (int t = 0; t < 8220; t++) begin
            @(posedge clk); #1;
            if (sact) n++;
        end
        chk("clamped count active cycles", 32'(n), 32'd8192);

        bus_wr(16'd3, 8'd4); bus_wr(16'd4, 8'd0);
`ifdef SEQ_PLAY_EXT_START_EN
        bus_wr(16'd2, 8'd1);
        bus_rd(16'd2, rdat); chk("ext enable read", 32'(rdat), 32'd1);
        play_check(4, 0, 1, 8, 3, 8, "ext start", 1'b1);
        bus_wr(16'd2, 8'd0);
`else
        bus_wr(16'd2, 8'd1);
        bus_rd(16'd2, rdat); chk("reg2 reads zero", 32'(rdat), 32'd0);
`endif
        ext = 1'b1;
        @(posedge clk); #1;
        ext = 1'b0;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (sact) n++;
        end
        chk("ext start ignored", 32'(n), 32'd0);
        bus_rd(16'd1, rdat); chk("done after ignored ext", 32'(rdat), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
